// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for a multicycle MIPS-style datapath
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // FETCH is encoding 0 so an uninitialised register still looks like FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  state_e state_q, state_d;

  // State register; reset returns to FETCH without waiting for a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control outputs; reset overrides outputs combinationally
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcen     = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 computed every fetch cycle; IR/PC only load on the ready cycle
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target precomputed into ALUOut while opcode is decoded
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWR: begin
        // Write strobe held for the whole access, including stall cycles
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end

      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end

      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = zero;
        state_d = S_FETCH;
      end

      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // While reset is held every strobe is quiet and the muxes show FETCH selects
    if (!reset_n) begin
      state_d  = S_FETCH;
      mem_req  = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b01;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {mem_req,memwrite,iord,irwrite,pcen,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,aluop,illegal}
  logic [15:0] act;
  assign act = {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
                alusrca, alusrcb, pcsrc, aluop, illegal};

  localparam logic [15:0] FR   = 16'b100110000_01_00_00_0;
  localparam logic [15:0] FS   = 16'b100000000_01_00_00_0;
  localparam logic [15:0] DEC  = 16'b000000000_11_00_00_0;
  localparam logic [15:0] DILL = 16'b000000000_11_00_00_1;
  localparam logic [15:0] MA   = 16'b000000001_10_00_00_0;
  localparam logic [15:0] MRD  = 16'b101000000_00_00_00_0;
  localparam logic [15:0] MWB  = 16'b000001010_00_00_00_0;
  localparam logic [15:0] MWR  = 16'b111000000_00_00_00_0;
  localparam logic [15:0] EXE  = 16'b000000001_00_00_10_0;
  localparam logic [15:0] AWB  = 16'b000001100_00_00_00_0;
  localparam logic [15:0] BR1  = 16'b000010001_00_01_01_0;
  localparam logic [15:0] BR0  = 16'b000000001_00_01_01_0;
  localparam logic [15:0] AEX  = 16'b000000001_10_00_00_0;
  localparam logic [15:0] AWB2 = 16'b000001000_00_00_00_0;
  localparam logic [15:0] JMP  = 16'b000010000_00_10_00_0;
  localparam logic [15:0] RST  = 16'b000000000_01_00_00_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010, XX = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic z, input logic r,
                     input logic [15:0] e, input string nm);
    vec_t v;
    v.op = o; v.zero = z; v.rdy = r; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard sink: compare the oldest expectation on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      chk(name_q.pop_front(), act, exp_q.pop_front());
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // lw, all ready: 5 cycles, write-back only in the last
    add(XX, 1, 1, FR,  "lw_fetch");
    add(LW, 1, 0, DEC, "lw_decode");
    add(LW, 1, 0, MA,  "lw_memadr");
    add(XX, 1, 1, MRD, "lw_memrd");
    add(XX, 1, 0, MWB, "lw_memwb");
    // sw with 3 stall cycles in MEMWR: 7 cycles, memwrite for 4
    add(XX, 1, 1, FR,  "sw_fetch");
    add(SW, 1, 0, DEC, "sw_decode");
    add(SW, 1, 0, MA,  "sw_memadr");
    add(XX, 1, 0, MWR, "sw_memwr_stall1");
    add(XX, 1, 0, MWR, "sw_memwr_stall2");
    add(XX, 1, 0, MWR, "sw_memwr_stall3");
    add(XX, 1, 1, MWR, "sw_memwr_ready");
    // R-type
    add(XX, 1, 1, FR,  "rt_fetch");
    add(RT, 1, 0, DEC, "rt_decode");
    add(XX, 1, 0, EXE, "rt_execute");
    add(XX, 1, 0, AWB, "rt_aluwb");
    // beq taken and not taken
    add(XX, 1, 1, FR,  "beq1_fetch");
    add(BQ, 1, 0, DEC, "beq1_decode");
    add(XX, 1, 0, BR1, "beq1_branch");
    add(XX, 0, 1, FR,  "beq0_fetch");
    add(BQ, 0, 0, DEC, "beq0_decode");
    add(XX, 0, 0, BR0, "beq0_branch");
    // addi
    add(XX, 1, 1, FR,  "addi_fetch");
    add(AI, 1, 0, DEC, "addi_decode");
    add(XX, 1, 0, AEX, "addi_exec");
    add(XX, 1, 0, AWB2,"addi_wb");
    // two-cycle fetch stall, then j
    add(XX, 1, 0, FS,  "j_fetch_stall1");
    add(XX, 1, 0, FS,  "j_fetch_stall2");
    add(XX, 1, 1, FR,  "j_fetch_ready");
    add(JP, 1, 0, DEC, "j_decode");
    add(XX, 1, 0, JMP, "j_jump");
    // illegal opcode, then lw with a MEMRD stall
    add(XX, 1, 1, FR,  "ill_fetch");
    add(XX, 1, 0, DILL,"ill_decode");
    add(XX, 1, 1, FR,  "ill_next_fetch");
    add(LW, 1, 0, DEC, "lw2_decode");
    add(LW, 1, 0, MA,  "lw2_memadr");
    add(XX, 1, 0, MRD, "lw2_memrd_stall");
    add(XX, 1, 1, MRD, "lw2_memrd_ready");
    add(XX, 1, 0, MWB, "lw2_memwb");

    // Reset asserted asynchronously before any clock edge
    reset_n = 1'b1; op = XX; zero = 1'b1; mem_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk("reset_async", act, RST);
    cyc();
    chk("reset_held", act, RST);
    cyc();
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      exp_q.push_back(vecs[i].exp);
      name_q.push_back(vecs[i].name);
      cyc();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end

    // Reset mid-cycle during EXECUTE
    mem_ready = 1'b1; zero = 1'b1; op = RT;
    cyc();
    chk("seq_decode", act, DEC);
    cyc();
    op = XX;
    #1 chk("seq_execute", act, EXE);
    #1 reset_n = 1'b0;
    #1 chk("exec_reset_async", act, RST);
    cyc();
    chk("exec_reset_hold", act, RST);
    #2 reset_n = 1'b1;
    #2 chk("exec_release_fetch", act, FR);
    op = SW;
    cyc();
    chk("rel_decode", act, DEC);
    cyc();
    chk("rel_memadr", act, MA);
    mem_ready = 1'b0;
    cyc();
    chk("rel_memwr_stall1", act, MWR);
    cyc();
    chk("rel_memwr_stall2", act, MWR);
    // Reset during a MEMWR stall must drop memwrite at once
    #2 reset_n = 1'b0;
    #1 chk("memwr_reset_memwrite", {15'd0, memwrite}, 16'd0);
    chk("memwr_reset_all", act, RST);
    cyc();
    reset_n = 1'b1;
    #2 chk("memwr_release_stall", act, FS);
    mem_ready = 1'b1;
    #1 chk("memwr_release_ready", act, FR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
